rs232_tx: RTL and testbench

RS232_TX -- requirements
Module: rs232_tx

---
 rtl/rs232_tx.sv | 122 ++++++++++++
 tb/tb_rs232_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx.sv
// RS232 byte serializer: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every line bit is advanced by the bit-rate enable from the RS232 clock generator.
module rs232_tx #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_rs232_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic STOP_LAST = (STOP_BITS == 2);

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic        stop_q, stop_d;
    logic        tx_q, tx_d;
    logic        parity;

    assign parity = (^data_q) ^ (PARITY_ODD != 0);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    data_d  = tx_data;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (clk_rs232_en) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (clk_rs232_en) begin
                    tx_d    = data_q[0];
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (clk_rs232_en) begin
                    if (idx_q != 3'd7) begin
                        tx_d  = data_q[idx_q + 3'd1];
                        idx_d = idx_q + 3'd1;
                    end else if (PARITY_EN != 0) begin
                        tx_d    = parity;
                        state_d = PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = STOP;
                    end
                end
            end
            PARITY: begin
                if (clk_rs232_en) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                // Once the final stop bit is on the line, release to IDLE so that a
                // waiting byte's start bit lands on the enable that ends this stop bit.
                if (stop_q == STOP_LAST) begin
                    state_d = IDLE;
                end else if (clk_rs232_en) begin
                    stop_d = stop_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: four parameterisations share one stimulus stream and are checked
// every cycle against a frame-level reference model, plus directed frame captures.
module tb_rs232_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [3:0] tx_w, ready_w, busy_w;

    always #5 clk = ~clk;

    rs232_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_def (
        .clk(clk), .rst(rst), .clk_rs232_en(en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]));
    rs232_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .clk_rs232_en(en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]));
    rs232_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .clk_rs232_en(en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]));
    rs232_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .clk_rs232_en(en), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]));

    int pe_tab[4] = '{0, 1, 1, 0};
    int po_tab[4] = '{0, 0, 1, 0};
    int sb_tab[4] = '{1, 1, 1, 2};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int phase = 0;

    // Reference model: a frame is a list of line bits, one emitted per enable.
    bit m_busy[4];
    bit m_done[4];
    bit m_line[4];
    bit m_acc[4];
    int m_pos[4];
    int m_len[4];
    bit m_frame[4][12];

    bit          cap_on = 1'b0;
    int          cap_n = 0;
    logic [11:0] cap[4];

    typedef struct {
        logic [7:0] data;
        logic       p_even;
    } vec_t;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_busy[c] = 1'b0;
            m_done[c] = 1'b0;
            m_line[c] = 1'b1;
            m_acc[c]  = 1'b0;
            m_pos[c]  = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 4; c++) begin
            m_acc[c] = 1'b0;
            if (!m_busy[c]) begin
                if (tx_valid) begin
                    int n;
                    m_frame[c][0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_frame[c][i + 1] = tx_data[i];
                    n = 9;
                    if (pe_tab[c] != 0) begin
                        m_frame[c][9] = (^tx_data) ^ (po_tab[c] != 0);
                        n = 10;
                    end
                    for (int s = 0; s < sb_tab[c]; s++) begin
                        m_frame[c][n] = 1'b1;
                        n++;
                    end
                    m_len[c]  = n;
                    m_pos[c]  = 0;
                    m_busy[c] = 1'b1;
                    m_done[c] = 1'b0;
                    m_acc[c]  = 1'b1;
                end
            end else if (m_done[c]) begin
                m_busy[c] = 1'b0;
            end else if (en) begin
                m_line[c] = m_frame[c][m_pos[c]];
                m_pos[c]++;
                if (m_pos[c] == m_len[c]) m_done[c] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        en = (phase == 0);
        phase = (phase + 1) % 4;
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        if (cap_on && en && cap_n < 12) begin
            for (int c = 0; c < 4; c++) cap[c][cap_n] = tx_w[c];
            cap_n++;
        end
        for (int c = 0; c < 4; c++) begin
            logic [2:0] act, exp;
            act = {tx_w[c], ready_w[c], busy_w[c]};
            exp = {m_line[c], !m_busy[c], m_busy[c]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle%0d inst%0d tx/ready/busy: got %b expected %b", cyc, c, act, exp);
            end
        end
        cyc++;
    endtask

    function automatic logic [11:0] frame_mask(input int c);
        int len;
        len = 10 + pe_tab[c] + sb_tab[c] - 1;
        return 12'hFFF >> (12 - len);
    endfunction

    function automatic logic [11:0] exp_frame(input int c, input logic [7:0] d, input logic p_even);
        logic [11:0] v;
        v = 12'hFFF;
        v[0] = 1'b0;
        v[8:1] = d;
        if (pe_tab[c] != 0) v[9] = (po_tab[c] != 0) ? ~p_even : p_even;
        return v;
    endfunction

    task automatic check_frames(input string tag, input logic [7:0] d, input logic p_even);
        for (int c = 0; c < 4; c++) begin
            check_val($sformatf("%s frame %02h inst%0d", tag, d, c),
                      int'(cap[c] & frame_mask(c)), int'(exp_frame(c, d, p_even) & frame_mask(c)));
        end
    endtask

    task automatic wait_cap(input int n);
        int guard = 0;
        while (cap_n < n && guard < 100) begin
            tick();
            guard++;
        end
        if (cap_n < n) check_val("capture timeout", cap_n, n);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (ready_w != 4'hF && guard < 200) begin
            tick();
            guard++;
        end
        check_val("return to idle", int'(ready_w), 15);
    endtask

    task automatic accept_off_enable(input logic [7:0] d);
        while (phase == 0) tick();
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
    endtask

    task automatic send_capture(input logic [7:0] d);
        accept_off_enable(d);
        tx_valid = 1'b0;
        cap_on = 1'b1;
        cap_n  = 0;
        wait_cap(12);
        cap_on = 1'b0;
        tick();
    endtask

    initial begin
        vec_t vecs[9];
        int   n, n0, n3, guard, got_cnt;
        bit   got[4];

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h34, 1'b1};
        vecs[7] = '{8'h3C, 1'b0};
        vecs[8] = '{8'h6E, 1'b1};

        rst = 1'b1;
        en = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        model_reset();
        tick();
        tick();
        for (int c = 0; c < 4; c++)
            check_val($sformatf("reset state inst%0d", c), int'({tx_w[c], ready_w[c], busy_w[c]}), 3'b110);
        rst = 1'b0;
        tick();

        // Directed frames from the table.
        for (int v = 0; v < 9; v++) begin
            send_capture(vecs[v].data);
            check_frames("table", vecs[v].data, vecs[v].p_even);
        end

        // Back-to-back 0x55 then 0xAA with tx_valid held.
        wait_idle();
        accept_off_enable(8'h55);
        tx_data = 8'hAA;
        cap_on = 1'b1;
        cap_n  = 0;
        wait_cap(10);
        cap_on = 1'b0;
        check_val("b2b 55 frame stop2", int'(cap[3][9:0]), int'(exp_frame(3, 8'h55, 1'b0) & 12'h3FF));
        n = 0;
        n0 = -1;
        n3 = -1;
        while ((n0 < 0 || n3 < 0) && n < 40) begin
            tick();
            n++;
            if (n0 < 0 && tx_w[0] == 1'b0) n0 = n;
            if (n3 < 0 && tx_w[3] == 1'b0) n3 = n;
        end
        tx_valid = 1'b0;
        check_val("b2b stop high clks stop1", n0, 4);
        check_val("b2b stop high clks stop2", n3, 8);
        wait_idle();

        // Byte offered in the same IDLE cycle as an enable.
        while (phase != 0) tick();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n = 0;
        while (tx_w[0] != 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check_val("start delay after enable-coincident accept", n, 4);
        wait_idle();

        // Reset during data bit 3 of 0xFF, then a clean 0x00 frame.
        accept_off_enable(8'hFF);
        tx_valid = 1'b0;
        cap_on = 1'b1;
        cap_n  = 0;
        wait_cap(5);
        cap_on = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++)
            check_val($sformatf("mid-frame reset inst%0d", c), int'({tx_w[c], ready_w[c], busy_w[c]}), 3'b110);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        send_capture(8'h00);
        check_frames("after reset", 8'h00, 1'b0);

        // 0x12 offered while 0x34 is in flight.
        wait_idle();
        accept_off_enable(8'h34);
        tx_data = 8'h12;
        cap_on = 1'b1;
        cap_n  = 0;
        for (int c = 0; c < 4; c++) got[c] = 1'b0;
        got_cnt = 0;
        guard = 0;
        while ((cap_n < 12 || got_cnt < 4) && guard < 200) begin
            tick();
            guard++;
            for (int c = 0; c < 4; c++) begin
                if (m_acc[c] && !got[c]) begin
                    got[c] = 1'b1;
                    got_cnt++;
                end
            end
            if (got_cnt == 4) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        cap_on = 1'b0;
        check_val("0x12 accepted by all after 0x34", got_cnt, 4);
        check_frames("busy-offer", 8'h34, 1'b1);
        wait_idle();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        tx_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
